// File: rtl/key_entry_ctrl_pkg.sv
// Shared definitions for the key entry controller.
// Holds the FSM state encoding, the invalid-code marker returned by the
// one-hot-to-BCD encoder, and the one-hot constant for each switch input.
package key_entry_ctrl_pkg;

  localparam int unsigned NumKeys = 10;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDebounce = 2'd1,
    StCapture  = 2'd2,
    StWaitRel  = 2'd3
  } state_e;

  // Encoder result for anything that is not exactly one key
  localparam logic [3:0] InvalidCode = 4'hF;

  // One-hot pattern of each switch input
  localparam logic [NumKeys-1:0] SwIn0 = 10'h001;
  localparam logic [NumKeys-1:0] SwIn1 = 10'h002;
  localparam logic [NumKeys-1:0] SwIn2 = 10'h004;
  localparam logic [NumKeys-1:0] SwIn3 = 10'h008;
  localparam logic [NumKeys-1:0] SwIn4 = 10'h010;
  localparam logic [NumKeys-1:0] SwIn5 = 10'h020;
  localparam logic [NumKeys-1:0] SwIn6 = 10'h040;
  localparam logic [NumKeys-1:0] SwIn7 = 10'h080;
  localparam logic [NumKeys-1:0] SwIn8 = 10'h100;
  localparam logic [NumKeys-1:0] SwIn9 = 10'h200;

endpackage

// File: rtl/key_entry_ctrl_bcd_enc.sv
// One-hot to BCD encoder (purely combinational).
// Ports:
//   key  - 10-bit key vector, bit n = key n
//   code - BCD digit of the single set bit, InvalidCode otherwise
module key_entry_ctrl_bcd_enc
  import key_entry_ctrl_pkg::*;
(
  input  logic [NumKeys-1:0] key,
  output logic [3:0]         code
);

  always_comb begin
    code = InvalidCode;
    case (key)
      SwIn0:   code = 4'd0;
      SwIn1:   code = 4'd1;
      SwIn2:   code = 4'd2;
      SwIn3:   code = 4'd3;
      SwIn4:   code = 4'd4;
      SwIn5:   code = 4'd5;
      SwIn6:   code = 4'd6;
      SwIn7:   code = 4'd7;
      SwIn8:   code = 4'd8;
      SwIn9:   code = 4'd9;
      default: code = InvalidCode;
    endcase
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// Debounced 10-key keypad entry controller with a four-digit BCD buffer.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset, beats clr and the FSM
//   sw_in  - raw asynchronous switches, bit n = key n pressed
//   clr    - synchronous clear of the digit buffer (FSM untouched)
//   digits - four packed BCD digits, [3:0] newest, [15:12] oldest
//   cnt    - number of digits held, 0..4
//   valid  - one-cycle pulse when a digit is entered
//   err    - one-cycle pulse when a debounced press is not exactly one key
module key_entry_ctrl
  import key_entry_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4  // legal range 2..255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NumKeys-1:0] sw_in,
  input  logic               clr,
  output logic [15:0]        digits,
  output logic [2:0]         cnt,
  output logic               valid,
  output logic               err
);

  localparam logic [7:0] DebLast = 8'(DEB_CYCLES - 1);

  logic [NumKeys-1:0] sync1_q, sw_s_q;
  state_e             state_q, state_d;
  logic [NumKeys-1:0] key_q, key_d;
  logic [7:0]         dc_q, dc_d;
  logic [15:0]        digits_q, digits_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [3:0]         code;

  key_entry_ctrl_bcd_enc u_bcd_enc (
    .key  (key_q),
    .code (code)
  );

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    dc_d     = dc_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sw_s_q != '0) begin
          key_d   = sw_s_q;
          dc_d    = 8'd0;
          state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (sw_s_q == '0) begin
          state_d = StIdle;
        end else if (sw_s_q != key_q) begin
          // Pattern changed mid-debounce: restart on the new pattern
          key_d = sw_s_q;
          dc_d  = 8'd0;
        end else if (dc_q == DebLast) begin
          state_d = StCapture;
        end else begin
          dc_d = dc_q + 8'd1;
        end
      end
      StCapture: begin
        state_d = StWaitRel;
        dc_d    = 8'd0;
        if (code == InvalidCode) begin
          err_d = 1'b1;
        end else if (!clr) begin
          // A clear in this cycle drops the digit entirely
          digits_d = {digits_q[11:0], code};
          cnt_d    = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
          valid_d  = 1'b1;
        end
      end
      StWaitRel: begin
        // Any activity restarts the release count, so a second key held
        // over the first cannot produce a digit
        if (sw_s_q != '0) begin
          dc_d = 8'd0;
        end else if (dc_q == DebLast) begin
          state_d = StIdle;
        end else begin
          dc_d = dc_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      digits_d = 16'h0000;
      cnt_d    = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sw_s_q   <= '0;
      state_q  <= StIdle;
      key_q    <= '0;
      dc_q     <= 8'd0;
      digits_q <= 16'h0000;
      cnt_q    <= 3'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= sw_in;
      sw_s_q   <= sync1_q;
      state_q  <= state_d;
      key_q    <= key_d;
      dc_q     <= dc_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign digits = digits_q;
  assign cnt    = cnt_q;
  assign valid  = valid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Self-checking bench for key_entry_ctrl. Expected digit/error events are
// queued when a press is driven and popped by a monitor on each pulse.
module tb_key_entry_ctrl;
  import key_entry_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [9:0]  sw_in;
  logic [15:0] digits;
  logic [2:0]  cnt;
  logic        valid;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_err;
    logic [15:0] digits;
    logic [2:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_digits;
  logic [2:0]  m_cnt;

  key_entry_ctrl #(.DEB_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .clr    (clr),
    .digits (digits),
    .cnt    (cnt),
    .valid  (valid),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; sample point is 1 time unit after the edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_digit(input int k);
    exp_t e;
    m_digits = {m_digits[11:0], 4'(k)};
    m_cnt    = (m_cnt == 3'd4) ? 3'd4 : m_cnt + 3'd1;
    e.is_err = 1'b0;
    e.digits = m_digits;
    e.cnt    = m_cnt;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.digits = m_digits;
    e.cnt    = m_cnt;
    sb.push_back(e);
  endtask

  task automatic press_release(input logic [9:0] v, input int hold, input int rel);
    sw_in = v;
    step(hold);
    sw_in = '0;
    step(rel);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses never seen, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Pops one expectation per valid/err pulse
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && err === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL valid_err_overlap: valid=%b err=%b, want not both", valid, err);
      end else if (valid === 1'b1 || err === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: valid=%b err=%b digits=%h cnt=%0d, want none",
                   valid, err, digits, cnt);
        end else begin
          e = sb.pop_front();
          if (err !== e.is_err || digits !== e.digits || cnt !== e.cnt) begin
            errors++;
            $display("FAIL pulse: err=%b digits=%h cnt=%0d, want err=%b digits=%h cnt=%0d",
                     err, digits, cnt, e.is_err, e.digits, e.cnt);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    clr   = 1'b0;
    sw_in = '0;
    step(3);
    checks++;
    if (digits !== 16'h0000) begin
      errors++;
      $display("FAIL reset_digits: got %h, want 0000", digits);
    end
    checks++;
    if (cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d, want 0", cnt);
    end
    checks++;
    if (valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: valid=%b err=%b, want 0 0", valid, err);
    end
    rst      = 1'b0;
    m_digits = 16'h0000;
    m_cnt    = 3'd0;
    step(2);
  endtask

  task automatic test_latency();
    logic is_idle;
    push_digit(7);
    sw_in = 10'h080;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      checks++;
      if (valid !== (e == 8)) begin
        errors++;
        $display("FAIL latency_edge%0d: valid=%b, want %b", e, valid, (e == 8));
      end
    end
    checks++;
    if (digits !== 16'h0007 || cnt !== 3'd1) begin
      errors++;
      $display("FAIL key7: digits=%h cnt=%0d, want 0007 1", digits, cnt);
    end
    sw_in = '0;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      is_idle = (dut.state_q == StIdle);
      checks++;
      if (is_idle !== (e == 6)) begin
        errors++;
        $display("FAIL release_edge%0d: idle=%b, want %b", e, is_idle, (e == 6));
      end
    end
    step(2);
    check_drained("latency_drain");
  endtask

  task automatic test_bounce();
    push_digit(2);
    for (int i = 0; i < 5; i++) begin
      sw_in = (i % 2 == 0) ? 10'h004 : 10'h000;
      step(2);
    end
    sw_in = 10'h004;
    step(14);
    sw_in = '0;
    step(10);
    check_drained("bounce_single_valid");
    checks++;
    if (digits[3:0] !== 4'd2) begin
      errors++;
      $display("FAIL bounce_digit: got %h, want 2", digits[3:0]);
    end
  endtask

  task automatic test_sequence();
    for (int k = 1; k <= 5; k++) begin
      push_digit(k);
      press_release(10'(1 << k), 12, 10);
    end
    check_drained("sequence_drain");
    checks++;
    if (digits !== 16'h2345 || cnt !== 3'd4) begin
      errors++;
      $display("FAIL sequence_full: digits=%h cnt=%0d, want 2345 4", digits, cnt);
    end
  endtask

  task automatic test_err();
    push_err();
    press_release(10'h0C0, 12, 10);
    check_drained("err_drain");
    checks++;
    if (digits !== 16'h2345 || cnt !== 3'd4) begin
      errors++;
      $display("FAIL err_unchanged: digits=%h cnt=%0d, want 2345 4", digits, cnt);
    end
  endtask

  task automatic test_clr_capture();
    logic in_cap;
    sw_in = 10'h200;
    step(7);
    in_cap = (dut.state_q == StCapture);
    checks++;
    if (in_cap !== 1'b1) begin
      errors++;
      $display("FAIL clr_in_capture: capture=%b, want 1", in_cap);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    checks++;
    if (digits !== 16'h0000 || cnt !== 3'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_capture: digits=%h cnt=%0d valid=%b, want 0000 0 0",
               digits, cnt, valid);
    end
    m_digits = 16'h0000;
    m_cnt    = 3'd0;
    step(5);
    sw_in = '0;
    step(10);
    check_drained("clr_no_valid");
    push_digit(3);
    press_release(10'h008, 12, 10);
    check_drained("after_clr_drain");
    checks++;
    if (digits !== 16'h0003 || cnt !== 3'd1) begin
      errors++;
      $display("FAIL after_clr: digits=%h cnt=%0d, want 0003 1", digits, cnt);
    end
  endtask

  task automatic test_reset_mid();
    sw_in = 10'h020;
    step(5);
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      checks++;
      if (digits !== 16'h0000 || cnt !== 3'd0 || valid !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset%0d: digits=%h cnt=%0d valid=%b err=%b, want all 0",
                 e, digits, cnt, valid, err);
      end
    end
    rst      = 1'b0;
    m_digits = 16'h0000;
    m_cnt    = 3'd0;
    push_digit(5);
    for (int e = 1; e <= 10; e++) begin
      step(1);
      checks++;
      if (valid !== (e == 8)) begin
        errors++;
        $display("FAIL post_reset_edge%0d: valid=%b, want %b", e, valid, (e == 8));
      end
    end
    sw_in = '0;
    step(10);
    check_drained("post_reset_drain");
    checks++;
    if (digits !== 16'h0005 || cnt !== 3'd1) begin
      errors++;
      $display("FAIL post_reset: digits=%h cnt=%0d, want 0005 1", digits, cnt);
    end
  endtask

  initial begin
    test_reset();
    fork
      monitor();
    join_none
    test_latency();
    test_bounce();
    test_sequence();
    test_err();
    test_clr_capture();
    test_reset_mid();
    step(2);
    check_drained("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
